// File: rtl/bbx_sample_walker.sv
// Walks every subsample position of a snapped bounding box in raster order,
// presenting one sample per cycle at R14 and stalling upstream until the box is done.
module bbx_sample_walker #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic [3:0]               subSample_RnnnnU,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic                     validSamp_R14H
);

  typedef enum logic {WAIT, WALK} state_t;

  state_t state, state_next;

  logic signed [SIGFIG-1:0] ll_x, ur_x, ur_y;
  logic [1:0]               ss_w_lg2;
  logic [4:0]               shift_amt;
  logic signed [SIGFIG:0]   step, next_x, next_y;
  logic                     x_fits, y_fits, is_last;

  // Lowest set bit of the one-hot config selects the finest grid.
  always_comb begin
    if (subSample_RnnnnU[0])      ss_w_lg2 = 2'd3;
    else if (subSample_RnnnnU[1]) ss_w_lg2 = 2'd2;
    else if (subSample_RnnnnU[2]) ss_w_lg2 = 2'd1;
    else                          ss_w_lg2 = 2'd0;
  end

  // One extra bit of headroom so stepping past a box near full scale cannot wrap.
  always_comb begin
    shift_amt = 5'(RADIX) - {3'b000, ss_w_lg2};
    step      = $signed({{SIGFIG{1'b0}}, 1'b1} << shift_amt);
    next_x    = {sample_R14S[0][SIGFIG-1], sample_R14S[0]} + step;
    next_y    = {sample_R14S[1][SIGFIG-1], sample_R14S[1]} + step;
    x_fits    = next_x <= {ur_x[SIGFIG-1], ur_x};
    y_fits    = next_y <= {ur_y[SIGFIG-1], ur_y};
    is_last   = !x_fits && !y_fits;
  end

  always_comb begin
    state_next  = state;
    halt_RnnnnL = 1'b1;
    case (state)
      WAIT: begin
        if (validTri_R13H) begin
          halt_RnnnnL = 1'b0;
          state_next  = WALK;
        end
      end
      WALK: begin
        if (is_last) state_next  = WAIT;
        else         halt_RnnnnL = 1'b0;
      end
      default: state_next = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT;
    else     state <= state_next;
  end

  // The triangle is only captured on acceptance, so it stays put through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      validSamp_R14H <= 1'b0;
      sample_R14S[0] <= '0;
      sample_R14S[1] <= '0;
      ll_x           <= '0;
      ur_x           <= '0;
      ur_y           <= '0;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          tri_R14S[v][a] <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (validTri_R13H) begin
            ll_x           <= box_R13S[0][0];
            ur_x           <= box_R13S[1][0];
            ur_y           <= box_R13S[1][1];
            sample_R14S[0] <= box_R13S[0][0];
            sample_R14S[1] <= box_R13S[0][1];
            tri_R14S       <= tri_R13S;
            validSamp_R14H <= 1'b1;
          end else begin
            validSamp_R14H <= 1'b0;
          end
        end
        WALK: begin
          if (x_fits) begin
            sample_R14S[0] <= next_x[SIGFIG-1:0];
          end else if (y_fits) begin
            sample_R14S[0] <= ll_x;
            sample_R14S[1] <= next_y[SIGFIG-1:0];
          end else begin
            validSamp_R14H <= 1'b0;
          end
        end
        default: validSamp_R14H <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bbx_sample_walker.sv
// Directed bench for bbx_sample_walker: expected samples are queued when a box
// is driven and popped as the walker presents them.
module tb_bbx_sample_walker;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;

  logic                     clk;
  logic                     rst;
  logic signed [SIGFIG-1:0] tri_in [VERTS][AXIS];
  logic signed [SIGFIG-1:0] box_in [2][2];
  logic                     valid_tri;
  logic [3:0]               sub_sample;
  logic                     halt_l;
  logic signed [SIGFIG-1:0] tri_out [VERTS][AXIS];
  logic signed [SIGFIG-1:0] sample_out [2];
  logic                     valid_samp;

  typedef struct {int x; int y;} samp_t;
  samp_t exp_q [$];

  int passed = 0;
  int total  = 0;

  bbx_sample_walker #(
    .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_in),
    .box_R13S         (box_in),
    .validTri_R13H    (valid_tri),
    .subSample_RnnnnU (sub_sample),
    .halt_RnnnnL      (halt_l),
    .tri_R14S         (tri_out),
    .sample_R14S      (sample_out),
    .validSamp_R14H   (valid_samp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Drives one box, walks it against the queued model; abort_at > 0 fires reset
  // while that sample number is presented; keep_valid leaves validTri high at the end.
  task automatic applyStimulus(input int llx, input int lly, input int urx, input int ury,
                               input logic [3:0] ss, input int tri_base,
                               input int abort_at, input bit keep_valid);
    int lg2, stp, seen;
    samp_t s;
    lg2 = ss[0] ? 3 : ss[1] ? 2 : ss[2] ? 1 : 0;
    stp = 1 << (RADIX - lg2);
    for (int y = lly; y <= ury; y += stp)
      for (int x = llx; x <= urx; x += stp)
        exp_q.push_back('{x: x, y: y});
    box_in[0][0] = llx; box_in[0][1] = lly;
    box_in[1][0] = urx; box_in[1][1] = ury;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        tri_in[v][a] = tri_base + v * AXIS + a;
    sub_sample = ss;
    valid_tri  = 1'b1;
    #1;
    checkOutput("accept_valid_low", valid_samp, 0);
    checkOutput("accept_halt", halt_l, 0);
    tick();
    seen = 0;
    while (exp_q.size() > 0) begin
      checkOutput("samp_valid", valid_samp, 1);
      if (!valid_samp) break;
      seen++;
      s = exp_q.pop_front();
      checkOutput("samp_x", sample_out[0], s.x);
      checkOutput("samp_y", sample_out[1], s.y);
      checkOutput("tri_00", tri_out[0][0], tri_base);
      checkOutput("tri_22", tri_out[2][2], tri_base + 8);
      if (seen == abort_at) begin
        rst = 1'b1;
        valid_tri = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("rst_valid", valid_samp, 0);
        checkOutput("rst_samp_x", sample_out[0], 0);
        checkOutput("rst_samp_y", sample_out[1], 0);
        checkOutput("rst_halt", halt_l, 1);
        exp_q.delete();
        return;
      end
      checkOutput("walk_halt", halt_l, (exp_q.size() == 0) ? 1 : 0);
      if (halt_l && !keep_valid) valid_tri = 1'b0;
      tick();
    end
    checkOutput("samples_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    valid_tri  = 1'b0;
    sub_sample = 4'b1000;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        tri_in[v][a] = '0;
    for (int i = 0; i < 2; i++) begin
      box_in[i][0] = '0;
      box_in[i][1] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_valid", valid_samp, 0);
    checkOutput("reset_halt", halt_l, 1);
    checkOutput("reset_samp_x", sample_out[0], 0);
    checkOutput("reset_tri", tri_out[1][1], 0);

    $display("[TB] basic walk");
    applyStimulus(0, 0, 2048, 1024, 4'b1000, 100, 0, 0);
    checkOutput("basic_done_valid", valid_samp, 0);
    checkOutput("basic_done_halt", halt_l, 1);
    checkOutput("tri_held_wait", tri_out[0][0], 100);

    $display("[TB] single-sample box");
    applyStimulus(3072, 5120, 3072, 5120, 4'b1000, 200, 0, 0);
    checkOutput("single_done_valid", valid_samp, 0);
    tick();
    checkOutput("single_wait_valid", valid_samp, 0);
    checkOutput("single_wait_halt", halt_l, 1);

    $display("[TB] fine subsample");
    applyStimulus(0, 0, 256, 128, 4'b0001, 300, 0, 0);
    checkOutput("fine_done_valid", valid_samp, 0);

    $display("[TB] back-to-back");
    applyStimulus(1024, 2048, 2048, 2048, 4'b1000, 400, 0, 1);
    applyStimulus(512, 0, 512, 512, 4'b0100, 500, 0, 0);
    checkOutput("b2b_done_valid", valid_samp, 0);

    $display("[TB] invalid input");
    valid_tri = 1'b0;
    for (int i = 0; i < 5; i++) begin
      box_in[0][0] = $urandom_range(0, 4096);
      box_in[1][0] = $urandom_range(4096, 8192);
      box_in[1][1] = $urandom_range(0, 8192);
      #1;
      checkOutput("invalid_halt", halt_l, 1);
      tick();
      checkOutput("invalid_valid", valid_samp, 0);
    end

    $display("[TB] reset mid-walk");
    applyStimulus(0, 0, 2048, 1024, 4'b1000, 600, 3, 0);
    applyStimulus(0, 0, 1024, 0, 4'b1000, 700, 0, 0);
    checkOutput("post_rst_done_valid", valid_samp, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
